// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - producer/consumer side of the RAM-backed FIFO controller
interface ram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
);
  logic                  flush;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_ready;
  logic                  pop;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, push, push_data, pop,
    input  push_ready, rd_valid, rd_data, count,
    input  empty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  flush, push, push_data, pop,
    output push_ready, rd_valid, rd_data, count,
    output empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO sequencer for an external 16x4 pseudo-dual-port RAM
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_fifo_ctrl_if.slave        fifo,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_re_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_data_b
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  empty_q;
  logic                  full_q;
  logic                  af_q;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  push_acc;
  logic                  pop_acc;

  // rst_n is active-high here; gating keeps the RAM idle while it is held.
  always_comb begin
    push_acc  = fifo.push & ~full_q  & ~fifo.flush & ~rst_n;
    pop_acc   = fifo.pop  & ~empty_q & ~fifo.flush & ~rst_n;
    count_nxt = count_q;
    if (push_acc && !pop_acc) begin
      count_nxt = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (fifo.flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_nxt;
      empty_q     <= (count_nxt == '0);
      full_q      <= (count_nxt == FULL_CNT);
      af_q        <= (count_nxt >= AF_CNT);
      rd_valid_q  <= pop_acc;
      overflow_q  <= overflow_q  | (fifo.push & full_q);
      underflow_q <= underflow_q | (fifo.pop  & empty_q);
    end
  end

  assign ram_wr_en   = push_acc;
  assign ram_addr_a  = wr_ptr_q;
  assign ram_data_a  = fifo.push_data;
  assign ram_re_en   = pop_acc;
  assign ram_addr_b  = rd_ptr_q;

  assign fifo.push_ready  = ~full_q;
  assign fifo.rd_valid    = rd_valid_q;
  assign fifo.rd_data     = ram_data_b;
  assign fifo.count       = count_q;
  assign fifo.empty       = empty_q;
  assign fifo.full        = full_q;
  assign fifo.almost_full = af_q;
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed self-checking bench for ram_fifo_ctrl with a behavioural RAM
module tb_ram_fifo_ctrl;
  logic       clk;
  logic       rst_n;
  logic       ram_wr_en;
  logic [3:0] ram_addr_a;
  logic [3:0] ram_data_a;
  logic       ram_re_en;
  logic [3:0] ram_addr_b;
  logic [3:0] ram_data_b;
  logic [3:0] mem [16];

  int checks   = 0;
  int failures = 0;

  ram_fifo_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus ();

  ram_fifo_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(4), .DEPTH(16), .AF_LEVEL(12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo      (bus.slave),
    .ram_wr_en (ram_wr_en),
    .ram_addr_a(ram_addr_a),
    .ram_data_a(ram_data_a),
    .ram_re_en (ram_re_en),
    .ram_addr_b(ram_addr_b),
    .ram_data_b(ram_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr_a] <= ram_data_a;
    if (ram_re_en) ram_data_b <= mem[ram_addr_b];
  end

  task automatic drive(input logic p, input logic [3:0] d, input logic q, input logic f);
    bus.push = p; bus.push_data = d; bus.pop = q; bus.flush = f;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(1'b1, 4'h3, 1'b1, 1'b0);
    step(); step();
    checks++;
    if ({ram_wr_en, ram_re_en, ram_addr_a, ram_addr_b} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ram_ctrl got=%b exp=0", {ram_wr_en, ram_re_en, ram_addr_a, ram_addr_b});
    end
    checks++;
    if ({bus.count, bus.empty, bus.full, bus.almost_full, bus.push_ready, bus.rd_valid, bus.overflow, bus.underflow}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state count=%0d e=%b f=%b af=%b pr=%b rv=%b ov=%b un=%b exp count=0 e=1 pr=1 rest 0",
               bus.count, bus.empty, bus.full, bus.almost_full, bus.push_ready, bus.rd_valid,
               bus.overflow, bus.underflow);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0);
      step();
    end
    checks++;
    if ({bus.count, bus.empty} !== {5'd5, 1'b0}) begin
      failures++;
      $display("FAIL basic_count got=%0d empty=%b exp=5 empty=0", bus.count, bus.empty);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      step();
      checks++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, 4'(i)}) begin
        failures++;
        $display("FAIL basic_pop%0d got rv=%b data=%h exp rv=1 data=%h", i, bus.rd_valid, bus.rd_data, 4'(i));
      end
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.rd_valid, bus.empty, bus.count} !== {1'b0, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL basic_end rv=%b empty=%b count=%0d exp rv=0 empty=1 count=0", bus.rd_valid, bus.empty, bus.count);
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_flags;
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 4'(k), 1'b0, 1'b0);
      step();
      exp_flags = {5'(k), k >= 12, k == 16, k != 16};
      checks++;
      if ({bus.count, bus.almost_full, bus.full, bus.push_ready} !== exp_flags) begin
        failures++;
        $display("FAIL fill_k%0d got count=%0d af=%b full=%b pr=%b exp=%b", k, bus.count,
                 bus.almost_full, bus.full, bus.push_ready, exp_flags);
      end
    end
    drive(1'b1, 4'hE, 1'b0, 1'b0);
    #1;
    checks++;
    if (ram_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL overflow_wr_en got=%b exp=0", ram_wr_en);
    end
    step();
    checks++;
    if ({bus.count, bus.overflow, bus.full} !== {5'd16, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL overflow_state count=%0d ov=%b full=%b exp 16 1 1", bus.count, bus.overflow, bus.full);
    end
  endtask

  // Starts full from test_fill: entries 1..15,0 with the read pointer at 5.
  task automatic test_back_to_back();
    logic [3:0] q [$];
    logic [3:0] rp;
    logic [3:0] exp_d;
    logic [4:0] mc;
    logic       pa;
    for (int k = 1; k <= 16; k++) q.push_back(4'(k));
    rp = 4'd5;
    mc = 5'd16;
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 4'(j + 7), 1'b1, 1'b0);
      #1;
      pa = (mc != 5'd16);
      checks++;
      if ({ram_wr_en, ram_re_en, ram_addr_b} !== {pa, 1'b1, rp}) begin
        failures++;
        $display("FAIL b2b_ctrl%0d got we=%b re=%b ab=%0d exp we=%b re=1 ab=%0d", j, ram_wr_en, ram_re_en,
                 ram_addr_b, pa, rp);
      end
      step();
      exp_d = q.pop_front();
      if (pa) q.push_back(4'(j + 7));
      else mc = mc - 5'd1;
      rp = rp + 4'd1;
      checks++;
      if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, exp_d, mc}) begin
        failures++;
        $display("FAIL b2b_data%0d got rv=%b d=%h count=%0d exp rv=1 d=%h count=%0d", j, bus.rd_valid,
                 bus.rd_data, bus.count, exp_d, mc);
      end
    end
    while (q.size() > 0) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      step();
      exp_d = q.pop_front();
      checks++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp_d}) begin
        failures++;
        $display("FAIL drain got rv=%b d=%h exp rv=1 d=%h", bus.rd_valid, bus.rd_data, exp_d);
      end
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.overflow, bus.empty, bus.count} !== {1'b0, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL flush_ovf ov=%b empty=%b count=%0d exp 0 1 0", bus.overflow, bus.empty, bus.count);
    end
  endtask

  task automatic test_underflow();
    drive(1'b1, 4'hA, 1'b1, 1'b0);
    #1;
    checks++;
    if ({ram_wr_en, ram_re_en} !== 2'b10) begin
      failures++;
      $display("FAIL underflow_en got we=%b re=%b exp we=1 re=0", ram_wr_en, ram_re_en);
    end
    step();
    checks++;
    if ({bus.underflow, bus.count, bus.rd_valid} !== {1'b1, 5'd1, 1'b0}) begin
      failures++;
      $display("FAIL underflow_state un=%b count=%0d rv=%b exp 1 1 0", bus.underflow, bus.count, bus.rd_valid);
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.rd_valid, bus.rd_data, bus.empty} !== {1'b1, 4'hA, 1'b1}) begin
      failures++;
      $display("FAIL underflow_next got rv=%b d=%h empty=%b exp 1 a 1", bus.rd_valid, bus.rd_data, bus.empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'hF, 1'b1, 1'b1);
    #1;
    checks++;
    if ({ram_wr_en, ram_re_en} !== 2'b00) begin
      failures++;
      $display("FAIL flush_en got we=%b re=%b exp 0 0", ram_wr_en, ram_re_en);
    end
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.count, bus.empty, bus.overflow, bus.underflow, bus.rd_valid}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_state count=%0d e=%b ov=%b un=%b rv=%b exp 0 1 0 0 0", bus.count, bus.empty,
               bus.overflow, bus.underflow, bus.rd_valid);
    end
    drive(1'b1, 4'h9, 1'b0, 1'b0);
    #1;
    checks++;
    if ({ram_wr_en, ram_addr_a} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL flush_ptr got we=%b aa=%0d exp we=1 aa=0", ram_wr_en, ram_addr_a);
    end
    step();
  endtask

  // FIFO holds one entry (0x9) on entry.
  task automatic test_async_reset();
    drive(1'b1, 4'h8, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 4'h9}) begin
      failures++;
      $display("FAIL prereset_pop got rv=%b d=%h exp 1 9", bus.rd_valid, bus.rd_data);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.rd_valid, bus.count, bus.empty} !== {1'b0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset rv=%b count=%0d empty=%b exp 0 0 1", bus.rd_valid, bus.count, bus.empty);
    end
    step();
    #2 rst_n = 1'b0;
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, 4'h6, 5'd0}) begin
      failures++;
      $display("FAIL post_reset got rv=%b d=%h count=%0d exp 1 6 0", bus.rd_valid, bus.rd_data, bus.count);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
